// File: rtl/microphone_pkg.sv
// microphone_pkg
//   Shared definitions for the multi-channel microphone controller:
//   mic/CPU FSM state encodings, the CPU word width and the FIFO entry
//   field layout ({channel, sample data}).
package microphone_pkg;

    // Width of the word presented to the CPU; samples are left-aligned in it.
    localparam int CPU_WORD_WIDTH      = 32;
    // Channel tag stored alongside each sample (0 = left, 1 = right).
    localparam int CHANNEL_FIELD_WIDTH = 1;

    typedef enum logic [2:0] {
        MIC_IDLE,
        MIC_ARM,
        MIC_PULSE,
        MIC_SHIFT,
        MIC_PUSH
    } mic_state_t;

    typedef enum logic [1:0] {
        CPU_IDLE,
        CPU_RESPONSE,
        CPU_CONSUME
    } cpu_state_t;

    // Total FIFO entry width for a given sample width.
    function automatic int entry_width(input int sample_width);
        return CHANNEL_FIELD_WIDTH + sample_width;
    endfunction

endpackage

// File: rtl/microphone_fifo.sv
// microphone_fifo
//   Synchronous FIFO, first-word-fall-through (rdata always shows the head).
//   Simultaneous push and pop are both honoured. The caller guarantees no
//   push when full and no pop when empty.
// Ports:
//   clock_25m    system clock, rising edge
//   reset_25m_n  asynchronous active-low reset (pointers/count only)
//   push, wdata  write one entry
//   pop          discard the head entry
//   rdata        head entry
//   count        occupancy, 0..DEPTH
//   empty        count == 0
module microphone_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 8
) (
    input  logic                     clock_25m,
    input  logic                     reset_25m_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;

    // NOTE: the storage array has no reset; only pointers and count need a
    // defined value, and leaving memories unreset keeps them in plain RAM.
    always_ff @(posedge clock_25m) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clock_25m or negedge reset_25m_n) begin
        if (!reset_25m_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + COUNT_W'(1);
                2'b01:   count <= count - COUNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rptr];
    assign empty = (count == '0);

endmodule

// File: rtl/microphone_multi.sv
// microphone_multi
//   WM8731 DSP-mode ADC capture for 1 or 2 channels, buffered in a FIFO and
//   handed to the CPU through a command/response handshake.
// Optional build macro: MICROPHONE_DROP_COUNT_EN adds microphone_drop_count,
//   a saturating count of dropped frames cleared by overflow_clear.
// Ports:
//   clock_25m, reset_25m_n   system clock / async active-low reset
//   clock_valid              0 freezes every register (reset still acts)
//   codec_initialized        CPU handshake is ignored until 1
//   clock_sample             async sample-rate clock; rising edge = new frame
//   microphone_command       CPU request level
//   microphone_response      registered response to the CPU
//   microphone_sample        FIFO head word, left-aligned, zero-padded
//   microphone_channel       channel tag of the head word (0 left, 1 right)
//   microphone_overflow      sticky dropped-frame flag
//   overflow_clear           clears the flag; wins over a same-cycle set
//   AUD_BCLK                 codec bit clock
//   AUD_ADCLRCK              frame sync pulse to the codec
//   AUD_ADCDAT               serial ADC data, MSB first
module microphone_multi
    import microphone_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 24,
    parameter int CHANNELS     = 2,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                      clock_25m,
    input  logic                      reset_25m_n,
    input  logic                      clock_valid,
    input  logic                      codec_initialized,
    input  logic                      clock_sample,
    input  logic                      microphone_command,
    output logic                      microphone_response,
    output logic [CPU_WORD_WIDTH-1:0] microphone_sample,
    output logic                      microphone_channel,
    output logic                      microphone_overflow,
    input  logic                      overflow_clear,
    input  logic                      AUD_BCLK,
    output logic                      AUD_ADCLRCK,
    input  logic                      AUD_ADCDAT
`ifdef MICROPHONE_DROP_COUNT_EN
    ,
    output logic [15:0]               microphone_drop_count
`endif
);

    localparam int TOTAL_BITS = CHANNELS * SAMPLE_WIDTH;
    localparam int BIT_W      = $clog2(TOTAL_BITS + 1);
    localparam int ENTRY_W    = entry_width(SAMPLE_WIDTH);
    localparam int COUNT_W    = $clog2(FIFO_DEPTH) + 1;

    // ------------------------------------------------------------------
    // Input conditioning: clock_sample synchronizer and BCLK edge detect
    // ------------------------------------------------------------------
    logic sample_sync1, sample_sync2, sample_last;
    logic bclk_last;
    logic sample_rise, bclk_rise, bclk_fall;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clock_25m or negedge reset_25m_n) begin
        if (!reset_25m_n) begin
            sample_sync1 <= 1'b0;
            sample_sync2 <= 1'b0;
            sample_last  <= 1'b0;
            bclk_last    <= 1'b1;
        end else if (clock_valid) begin
            sample_sync1 <= clock_sample;
            sample_sync2 <= sample_sync1;
            sample_last  <= sample_sync2;
            bclk_last    <= AUD_BCLK;
        end
    end

    assign sample_rise = sample_sync2 & ~sample_last;
    assign bclk_rise   = ~bclk_last & AUD_BCLK;
    assign bclk_fall   = bclk_last & ~AUD_BCLK;

    // ------------------------------------------------------------------
    // Mic FSM
    // ------------------------------------------------------------------
    mic_state_t              mic_state, mic_next;
    logic                    pending;
    logic [BIT_W-1:0]        bitcnt;
    logic [TOTAL_BITS-1:0]   shreg;
    logic                    push_ch;
    logic                    push_last;

    logic                    lrck_set, lrck_clr, pending_clr, shift_en;
    logic                    fifo_push, frame_drop, sample_drop;

    logic [ENTRY_W-1:0]      fifo_wdata, fifo_rdata;
    logic [COUNT_W-1:0]      fifo_count;
    logic                    fifo_empty, fifo_pop;

    assign push_last = (push_ch == 1'(CHANNELS - 1));

    always_ff @(posedge clock_25m or negedge reset_25m_n) begin
        if (!reset_25m_n) begin
            mic_state <= MIC_IDLE;
        end else if (clock_valid) begin
            mic_state <= mic_next;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        mic_next    = mic_state;
        lrck_set    = 1'b0;
        lrck_clr    = 1'b0;
        pending_clr = 1'b0;
        shift_en    = 1'b0;
        fifo_push   = 1'b0;
        frame_drop  = 1'b0;
        unique case (mic_state)
            MIC_IDLE: begin
                if (pending) mic_next = MIC_ARM;
            end
            MIC_ARM: begin
                if (bclk_fall) begin
                    lrck_set    = 1'b1;
                    pending_clr = 1'b1;
                    mic_next    = MIC_PULSE;
                end
            end
            MIC_PULSE: begin
                // Exactly one BCLK rise lies between the arming fall and the
                // next fall, so waiting for a fall skips that first rise.
                if (bclk_fall) begin
                    lrck_clr = 1'b1;
                    mic_next = MIC_SHIFT;
                end
            end
            MIC_SHIFT: begin
                if (bclk_rise) begin
                    shift_en = 1'b1;
                    if (bitcnt == BIT_W'(TOTAL_BITS - 1)) mic_next = MIC_PUSH;
                end
            end
            MIC_PUSH: begin
                // Room for the whole frame is checked once, before the left
                // word; pops in the meantime only add room.
                if (!push_ch && (fifo_count > COUNT_W'(FIFO_DEPTH - CHANNELS))) begin
                    frame_drop = 1'b1;
                    mic_next   = MIC_IDLE;
                end else begin
                    fifo_push = 1'b1;
                    if (push_last) mic_next = MIC_IDLE;
                end
            end
            default: mic_next = MIC_IDLE;
        endcase
    end

    // A new sample edge while the previous frame has not yet started is lost.
    assign sample_drop = sample_rise & pending;

    always_ff @(posedge clock_25m or negedge reset_25m_n) begin
        if (!reset_25m_n) begin
            pending             <= 1'b0;
            AUD_ADCLRCK         <= 1'b0;
            bitcnt              <= '0;
            shreg               <= '0;
            push_ch             <= 1'b0;
            microphone_overflow <= 1'b0;
        end else if (clock_valid) begin
            if (pending_clr)      pending <= 1'b0;
            else if (sample_rise) pending <= 1'b1;

            if (lrck_set)      AUD_ADCLRCK <= 1'b1;
            else if (lrck_clr) AUD_ADCLRCK <= 1'b0;

            if (lrck_clr)      bitcnt <= '0;
            else if (shift_en) bitcnt <= bitcnt + BIT_W'(1);

            // The top SAMPLE_WIDTH bits always hold the next word to push.
            if (shift_en)       shreg <= {shreg[TOTAL_BITS-2:0], AUD_ADCDAT};
            else if (fifo_push) shreg <= shreg << SAMPLE_WIDTH;

            if (fifo_push) push_ch <= push_last ? 1'b0 : 1'b1;

            if (overflow_clear)                  microphone_overflow <= 1'b0;
            else if (frame_drop || sample_drop)  microphone_overflow <= 1'b1;
        end
    end

`ifdef MICROPHONE_DROP_COUNT_EN
    logic [1:0]  drop_events;
    logic [15:0] drop_count;

    assign drop_events = {1'b0, frame_drop} + {1'b0, sample_drop};

    always_ff @(posedge clock_25m or negedge reset_25m_n) begin
        if (!reset_25m_n) begin
            drop_count <= '0;
        end else if (clock_valid) begin
            if (overflow_clear) begin
                drop_count <= '0;
            end else if (drop_events != 2'd0) begin
                if (drop_count > 16'hFFFF - 16'(drop_events)) drop_count <= 16'hFFFF;
                else                                           drop_count <= drop_count + 16'(drop_events);
            end
        end
    end

    assign microphone_drop_count = drop_count;
`endif

    // ------------------------------------------------------------------
    // Sample FIFO
    // ------------------------------------------------------------------
    logic cpu_pop;

    assign fifo_wdata = {push_ch, shreg[TOTAL_BITS-1 -: SAMPLE_WIDTH]};
    assign fifo_pop   = cpu_pop & clock_valid;

    microphone_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock_25m   (clock_25m),
        .reset_25m_n (reset_25m_n),
        .push        (fifo_push & clock_valid),
        .pop         (fifo_pop),
        .wdata       (fifo_wdata),
        .rdata       (fifo_rdata),
        .count       (fifo_count),
        .empty       (fifo_empty)
    );

    // Head is forced to zero while empty so the outputs are defined from reset.
    logic [CPU_WORD_WIDTH-1:0] head_word;
    assign head_word = CPU_WORD_WIDTH'(fifo_rdata[SAMPLE_WIDTH-1:0]) << (CPU_WORD_WIDTH - SAMPLE_WIDTH);

    assign microphone_sample  = fifo_empty ? '0   : head_word;
    assign microphone_channel = fifo_empty ? 1'b0 : fifo_rdata[SAMPLE_WIDTH];

    // ------------------------------------------------------------------
    // CPU FSM
    // ------------------------------------------------------------------
    cpu_state_t cpu_state, cpu_next;

    always_ff @(posedge clock_25m or negedge reset_25m_n) begin
        if (!reset_25m_n) begin
            cpu_state           <= CPU_IDLE;
            microphone_response <= 1'b0;
        end else if (clock_valid) begin
            cpu_state           <= cpu_next;
            microphone_response <= (cpu_state == CPU_RESPONSE);
        end
    end

    always_comb begin
        cpu_next = cpu_state;
        cpu_pop  = 1'b0;
        unique case (cpu_state)
            CPU_IDLE: begin
                if (microphone_command && !fifo_empty && codec_initialized) cpu_next = CPU_RESPONSE;
            end
            CPU_RESPONSE: begin
                if (!microphone_command) cpu_next = CPU_CONSUME;
            end
            CPU_CONSUME: begin
                // Only this state pops, so the head is stable during RESPONSE.
                cpu_pop  = 1'b1;
                cpu_next = CPU_IDLE;
            end
            default: cpu_next = CPU_IDLE;
        endcase
    end

endmodule
